// File: rtl/flick_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flick_cond_pkg
// Brief    : Shared state encoding and default timing constants for the
//            flick_conditioner push-button input stage.
// Revision : 1.0 - initial release
// ============================================================================
package flick_cond_pkg;

  // Conditioner states; flick is low in LOW/CONF_H and high in HIGH/CONF_L.
  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CONF_H = 2'd1,
    HIGH   = 2'd2,
    CONF_L = 2'd3
  } flick_state_e;

  // Default timing used when the top is instantiated without overrides.
  localparam int c_def_sync_stages     = 2;
  localparam int c_def_debounce_cycles = 4;
  localparam int c_def_min_high_cycles = 8;

endpackage : flick_cond_pkg
`default_nettype wire

// File: rtl/flick_conditioner_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : Parameterised N-flop synchroniser for an asynchronous level.
//            Synchronous active-high reset clears every stage.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the chain; bit 0 is the metastable-prone flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/flick_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : flick_conditioner
// Brief    : Synchronises, debounces and stretches a raw push-button into the
//            clean flick level consumed by bound_flasher. Also provides rise
//            and glitch strobes plus a saturating accepted-press counter.
// Revision : 1.0 - initial release
// ============================================================================
module flick_conditioner
  import flick_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = c_def_sync_stages,
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles,
  parameter int MIN_HIGH_CYCLES = c_def_min_high_cycles,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  output logic             flick,
  output logic             flick_rise,
  output logic             glitch,
  output logic [CNT_W-1:0] press_cnt
);

  // Counter widths sized so the terminal value fits without wrapping.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(MIN_HIGH_CYCLES + 1);

  // A confirmation completes when the counter already holds N-1 samples and
  // one more agreeing sample arrives.
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_DONE  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_FULL  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             btn_s;

  flick_state_e     state_q,  state_d;
  logic [DB_W-1:0]  db_q,     db_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic             flick_q,  flick_d;
  logic             rise_q,   rise_d;
  logic             glitch_q, glitch_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_s)
  );

  // Next-state and registered-output decode for the debounce/stretch FSM.
  always_comb begin
    state_d  = state_q;
    db_d     = db_q;
    hold_d   = hold_q;
    flick_d  = flick_q;
    rise_d   = 1'b0;
    glitch_d = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      LOW: begin
        flick_d = 1'b0;
        if (btn_s) begin
          state_d = CONF_H;
          db_d    = DB_ONE;
        end
      end

      CONF_H: begin
        if (btn_s) begin
          if (db_q >= DB_DONE) begin
            // Press accepted: raise flick and restart the stretch timer.
            state_d = HIGH;
            db_d    = DB_FULL;
            flick_d = 1'b1;
            rise_d  = 1'b1;
            hold_d  = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            db_d = db_q + DB_ONE;
          end
        end else begin
          state_d  = LOW;
          glitch_d = 1'b1;
        end
      end

      HIGH: begin
        flick_d = 1'b1;
        if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        // A release seen before the stretch expires is simply ignored.
        if (!btn_s && (hold_q >= HOLD_MAX)) begin
          state_d = CONF_L;
          db_d    = DB_ONE;
        end
      end

      CONF_L: begin
        flick_d = 1'b1;
        if (!btn_s) begin
          if (db_q >= DB_DONE) begin
            state_d = LOW;
            db_d    = DB_FULL;
            flick_d = 1'b0;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end else begin
          // Release bounce: back to HIGH, hold stays saturated so the next
          // clean low sample restarts confirmation immediately.
          state_d  = HIGH;
          glitch_d = 1'b1;
        end
      end

      default: begin
        state_d = LOW;
        flick_d = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOW;
      db_q     <= '0;
      hold_q   <= '0;
      flick_q  <= 1'b0;
      rise_q   <= 1'b0;
      glitch_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      db_q     <= db_d;
      hold_q   <= hold_d;
      flick_q  <= flick_d;
      rise_q   <= rise_d;
      glitch_q <= glitch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign flick      = flick_q;
  assign flick_rise = rise_q;
  assign glitch     = glitch_q;
  assign press_cnt  = cnt_q;

endmodule : flick_conditioner
`default_nettype wire

// File: tb/tb_flick_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_flick_conditioner
// Brief    : Self-checking bench for flick_conditioner. Expected per-edge
//            outputs are derived from the documented edge timing, queued when
//            the stimulus is driven and compared after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flick_conditioner;

  typedef struct packed {
    logic       flick;
    logic       rise;
    logic       glitch;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       flick;
  logic       flick_rise;
  logic       glitch;
  logic [7:0] press_cnt;
  logic       s_flick;
  logic       s_rise;
  logic       s_glitch;
  logic [1:0] s_cnt;

  exp_t sb_q[$];
  int   sat_q[$];
  int   checks;
  int   failures;

  flick_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .flick      (flick),
    .flick_rise (flick_rise),
    .glitch     (glitch),
    .press_cnt  (press_cnt)
  );

  flick_conditioner #(
    .CNT_W (2)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .flick      (s_flick),
    .flick_rise (s_rise),
    .glitch     (s_glitch),
    .press_cnt  (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic f, input logic r, input logic g, input int c);
    exp_t e;
    e.flick  = f;
    e.rise   = r;
    e.glitch = g;
    e.cnt    = 8'(c);
    return e;
  endfunction

  task automatic apply_reset();
    rst     = 1'b1;
    btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t a;
    btn_raw = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", i, a, e);
      end
    end
    // Button still held as reset releases: counts as a fresh press.
    rst = 1'b0;
    for (int ed = 1; ed <= 8; ed++) begin
      sb_q.push_back(mk(ed >= 6, ed == 6, 1'b0, (ed >= 6) ? 1 : 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset_release edge %0d: got %h want %h", ed, a, e);
      end
    end
  endtask

  task automatic test_long_press();
    exp_t e;
    exp_t a;
    apply_reset();
    for (int ed = 1; ed <= 32; ed++) begin
      btn_raw = (ed <= 20);
      sb_q.push_back(mk(ed >= 6 && ed <= 25, ed == 6, 1'b0, (ed >= 6) ? 1 : 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL long_press edge %0d: got %h want %h", ed, a, e);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    exp_t a;
    apply_reset();
    for (int ed = 1; ed <= 12; ed++) begin
      btn_raw = (ed <= 3);
      sb_q.push_back(mk(1'b0, 1'b0, ed == 6, 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL bounce edge %0d: got %h want %h", ed, a, e);
      end
    end
  endtask

  task automatic test_short_press();
    exp_t e;
    exp_t a;
    apply_reset();
    for (int ed = 1; ed <= 24; ed++) begin
      btn_raw = (ed <= 5);
      sb_q.push_back(mk(ed >= 6 && ed <= 17, ed == 6, 1'b0, (ed >= 6) ? 1 : 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL short_press edge %0d: got %h want %h", ed, a, e);
      end
    end
  endtask

  task automatic test_release_bounce();
    exp_t e;
    exp_t a;
    apply_reset();
    // Release at edge 21, one-cycle bounce sampled at edge 23 (lands in CONF_L).
    for (int ed = 1; ed <= 34; ed++) begin
      btn_raw = (ed <= 20) || (ed == 23);
      sb_q.push_back(mk(ed >= 6 && ed <= 28, ed == 6, ed == 25, (ed >= 6) ? 1 : 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL release_bounce edge %0d: got %h want %h", ed, a, e);
      end
    end
  endtask

  task automatic test_reset_mid_high();
    exp_t e;
    exp_t a;
    apply_reset();
    for (int ed = 1; ed <= 10; ed++) begin
      btn_raw = 1'b1;
      sb_q.push_back(mk(ed >= 6, ed == 6, 1'b0, (ed >= 6) ? 1 : 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL mid_high_pre edge %0d: got %h want %h", ed, a, e);
      end
    end
    rst = 1'b1;
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    @(posedge clk); #1;
    e = sb_q.pop_front();
    a = {flick, flick_rise, glitch, press_cnt};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL mid_high_reset: got %h want %h", a, e);
    end
    rst = 1'b0;
    for (int ed = 1; ed <= 12; ed++) begin
      sb_q.push_back(mk(ed >= 6, ed == 6, 1'b0, (ed >= 6) ? 1 : 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL mid_high_post edge %0d: got %h want %h", ed, a, e);
      end
    end
    btn_raw = 1'b0;
  endtask

  task automatic test_saturation();
    exp_t e;
    exp_t a;
    int   se;
    apply_reset();
    for (int p = 1; p <= 5; p++) begin
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, p));
      sat_q.push_back((p > 3) ? 3 : p);
      for (int ed = 1; ed <= 40; ed++) begin
        btn_raw = (ed <= 20);
        @(posedge clk); #1;
      end
      e = sb_q.pop_front();
      a = {flick, flick_rise, glitch, press_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL press_count press %0d: got %h want %h", p, a, e);
      end
      se = sat_q.pop_front();
      checks++;
      if (s_cnt !== 2'(se)) begin
        failures++;
        $display("FAIL sat_count press %0d: got %0d want %0d", p, s_cnt, se);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn_raw  = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_long_press();
    test_bounce();
    test_short_press();
    test_release_bounce();
    test_reset_mid_high();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_flick_conditioner
`default_nettype wire
